y_capture: RTL and testbench

Write-side companion to the waveform drawing block: captures one selected video line per frame, converts each RGB pixel to 8-bit luma, and writes up to 256 luma samples into the shared 256x8 waveform RAM, addressed by horizontal pixel position. Sits on the incoming video stream, upstream of the RAM that the drawing block reads. Frame geometry comes from the same 36-bit control word format the drawing block emits.

---
 rtl/y_capture.sv | 227 ++++++++++++++++++++++
 tb/tb_y_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/y_capture.sv
// rtl/y_capture.sv - captures one selected video line per frame as 8-bit luma into the waveform RAM
module y_capture #(
    parameter int WIDTH  = 256,
    parameter int HEIGHT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        video_valid,
    output logic        video_ready,
    input  logic [23:0] video_data,
    input  logic        frame_sync,
    input  logic [35:0] in_control_data,
    input  logic        in_control_valid,
    input  logic [15:0] line_sel,
    input  logic        freeze,
    output logic [7:0]  ram_wrdata,
    output logic [7:0]  ram_addr,
    output logic        ram_wr,
    output logic        capture_done
);

    typedef enum logic [1:0] {
        ARMED   = 2'd0,
        CAPTURE = 2'd1,
        HOLD    = 2'd2
    } state_t;

    localparam logic [15:0] DEF_W = 16'(WIDTH);
    localparam logic [15:0] DEF_H = 16'(HEIGHT);

    // Registered state
    logic        ready_q, ready_d;
    logic        ready_arm_q, ready_arm_d;
    logic        sof_q, sof_d;
    logic [15:0] x_cnt_q, x_cnt_d;
    logic [15:0] y_cnt_q, y_cnt_d;
    logic [15:0] shadow_w_q, shadow_w_d;
    logic [15:0] shadow_h_q, shadow_h_d;
    logic [15:0] width_act_q, width_act_d;
    logic [15:0] height_act_q, height_act_d;
    logic [15:0] line_act_q, line_act_d;
    logic        freeze_act_q, freeze_act_d;
    state_t      state_q, state_d;
    logic        s1_wr_q, s1_wr_d;
    logic [7:0]  s1_addr_q, s1_addr_d;
    logic [23:0] s1_rgb_q, s1_rgb_d;
    logic        s1_done_q, s1_done_d;
    logic        ram_wr_q, ram_wr_d;
    logic [7:0]  ram_addr_q, ram_addr_d;
    logic [7:0]  ram_wrdata_q, ram_wrdata_d;
    logic        done_q, done_d;

    // Per-pixel combinational helpers
    logic        accept;
    logic        frame_start;
    logic [15:0] w_eff, h_eff, line_eff, last_x;
    logic        freeze_eff;
    state_t      cur_state;
    logic        pix_wr, pix_done;
    logic [15:0] luma_sum;
    logic        unused_ctrl_bits;

    // The interlace field of the control word has no meaning for capture
    assign unused_ctrl_bits = ^in_control_data[3:0];

    assign accept      = video_valid & ready_q;
    assign frame_start = accept & sof_q;

    // On the frame-start pixel the freshly sampled geometry and selection apply immediately
    always_comb begin
        w_eff      = frame_start ? shadow_w_q : width_act_q;
        h_eff      = frame_start ? shadow_h_q : height_act_q;
        line_eff   = frame_start ? line_sel   : line_act_q;
        freeze_eff = frame_start ? freeze     : freeze_act_q;
        last_x     = (w_eff > 16'd256) ? 16'd255 : (w_eff - 16'd1);
        cur_state  = frame_start ? ARMED : state_q;
    end

    // Capture FSM: decides whether the accepted pixel is written and whether it ends the line
    always_comb begin
        state_d  = state_q;
        pix_wr   = 1'b0;
        pix_done = 1'b0;
        if (accept) begin
            state_d = cur_state;
            case (cur_state)
                ARMED: begin
                    if ((y_cnt_q == line_eff) && !freeze_eff) begin
                        pix_wr = (x_cnt_q < 16'd256);
                        if (x_cnt_q == last_x) begin
                            pix_done = 1'b1;
                            state_d  = HOLD;
                        end else begin
                            state_d = CAPTURE;
                        end
                    end
                end
                CAPTURE: begin
                    pix_wr = (x_cnt_q < 16'd256);
                    if (x_cnt_q == last_x) begin
                        pix_done = 1'b1;
                        state_d  = HOLD;
                    end
                end
                default: begin
                    state_d = HOLD;
                end
            endcase
        end
    end

    // Raster counters, frame tracking, control shadow and per-frame sampled settings
    always_comb begin
        ready_arm_d  = 1'b1;
        ready_d      = ready_arm_q;
        sof_d        = sof_q;
        x_cnt_d      = x_cnt_q;
        y_cnt_d      = y_cnt_q;
        shadow_w_d   = shadow_w_q;
        shadow_h_d   = shadow_h_q;
        width_act_d  = width_act_q;
        height_act_d = height_act_q;
        line_act_d   = line_act_q;
        freeze_act_d = freeze_act_q;

        if (frame_start) begin
            width_act_d  = shadow_w_q;
            height_act_d = shadow_h_q;
            line_act_d   = line_sel;
            freeze_act_d = freeze;
        end

        // A word arriving with the frame-start pixel only reaches the shadow
        if (in_control_valid) begin
            shadow_w_d = (in_control_data[35:20] == 16'd0) ? DEF_W : in_control_data[35:20];
            shadow_h_d = (in_control_data[19:4]  == 16'd0) ? DEF_H : in_control_data[19:4];
        end

        if (accept) begin
            sof_d = frame_sync;
            if (frame_sync) begin
                x_cnt_d = 16'd0;
                y_cnt_d = 16'd0;
            end else if (x_cnt_q == (w_eff - 16'd1)) begin
                x_cnt_d = 16'd0;
                y_cnt_d = (y_cnt_q == (h_eff - 16'd1)) ? 16'd0 : (y_cnt_q + 16'd1);
            end else begin
                x_cnt_d = x_cnt_q + 16'd1;
            end
        end
    end

    // Two-stage write pipeline: stage 1 holds the raw pixel, stage 2 drives the RAM port
    always_comb begin
        s1_wr_d   = pix_wr;
        s1_done_d = pix_done;
        s1_addr_d = x_cnt_q[7:0];
        s1_rgb_d  = video_data;

        luma_sum = 16'd77  * {8'd0, s1_rgb_q[23:16]}
                 + 16'd150 * {8'd0, s1_rgb_q[15:8]}
                 + 16'd29  * {8'd0, s1_rgb_q[7:0]};

        ram_wr_d     = s1_wr_q;
        done_d       = s1_done_q;
        ram_addr_d   = ram_addr_q;
        ram_wrdata_d = ram_wrdata_q;
        if (s1_wr_q) begin
            ram_addr_d   = s1_addr_q;
            ram_wrdata_d = luma_sum[15:8];
        end
    end

    // State register; reset also flushes any pixels still in the write pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            ready_q      <= 1'b0;
            ready_arm_q  <= 1'b0;
            sof_q        <= 1'b1;
            x_cnt_q      <= 16'd0;
            y_cnt_q      <= 16'd0;
            shadow_w_q   <= DEF_W;
            shadow_h_q   <= DEF_H;
            width_act_q  <= DEF_W;
            height_act_q <= DEF_H;
            line_act_q   <= 16'd0;
            freeze_act_q <= 1'b0;
            state_q      <= ARMED;
            s1_wr_q      <= 1'b0;
            s1_addr_q    <= 8'd0;
            s1_rgb_q     <= 24'd0;
            s1_done_q    <= 1'b0;
            ram_wr_q     <= 1'b0;
            ram_addr_q   <= 8'd0;
            ram_wrdata_q <= 8'd0;
            done_q       <= 1'b0;
        end else begin
            ready_q      <= ready_d;
            ready_arm_q  <= ready_arm_d;
            sof_q        <= sof_d;
            x_cnt_q      <= x_cnt_d;
            y_cnt_q      <= y_cnt_d;
            shadow_w_q   <= shadow_w_d;
            shadow_h_q   <= shadow_h_d;
            width_act_q  <= width_act_d;
            height_act_q <= height_act_d;
            line_act_q   <= line_act_d;
            freeze_act_q <= freeze_act_d;
            state_q      <= state_d;
            s1_wr_q      <= s1_wr_d;
            s1_addr_q    <= s1_addr_d;
            s1_rgb_q     <= s1_rgb_d;
            s1_done_q    <= s1_done_d;
            ram_wr_q     <= ram_wr_d;
            ram_addr_q   <= ram_addr_d;
            ram_wrdata_q <= ram_wrdata_d;
            done_q       <= done_d;
        end
    end

    assign video_ready  = ready_q;
    assign ram_wr       = ram_wr_q;
    assign ram_addr     = ram_addr_q;
    assign ram_wrdata   = ram_wrdata_q;
    assign capture_done = done_q;

endmodule

// File: tb/tb_y_capture.sv
// tb/tb_y_capture.sv - self-checking bench for y_capture against a line-capture reference model
module tb_y_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        video_valid;
    logic        video_ready;
    logic [23:0] video_data;
    logic        frame_sync;
    logic [35:0] in_control_data;
    logic        in_control_valid;
    logic [15:0] line_sel;
    logic        freeze;
    logic [7:0]  ram_wrdata;
    logic [7:0]  ram_addr;
    logic        ram_wr;
    logic        capture_done;

    y_capture #(.WIDTH(256), .HEIGHT(256)) dut (
        .clk             (clk),
        .rst             (rst),
        .video_valid     (video_valid),
        .video_ready     (video_ready),
        .video_data      (video_data),
        .frame_sync      (frame_sync),
        .in_control_data (in_control_data),
        .in_control_valid(in_control_valid),
        .line_sel        (line_sel),
        .freeze          (freeze),
        .ram_wrdata      (ram_wrdata),
        .ram_addr        (ram_addr),
        .ram_wr          (ram_wr),
        .capture_done    (capture_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         cyc;
        logic [7:0] addr;
        logic [7:0] data;
        logic       done;
    } wr_t;

    wr_t expq[$];
    int  nchk = 0;
    int  nerr = 0;
    int  sh_w = 256;
    int  sh_h = 256;
    logic [23:0] colors [4] = '{24'hFFFFFF, 24'hFF0000, 24'h00FF00, 24'h0000FF};

    function automatic logic [7:0] luma_of(input logic [23:0] p);
        int r, g, b;
        r = int'(p[23:16]);
        g = int'(p[15:8]);
        b = int'(p[7:0]);
        return 8'((77 * r + 150 * g + 29 * b) / 256);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Scoreboard: every write must match the oldest expected write, in content and cycle
    always @(negedge clk) begin
        if (ram_wr === 1'b1) begin
            nchk++;
            assert (expq.size() > 0) else begin
                nerr++;
                $error("FAIL unexpected_write addr=%0d data=%0d expected=no_write", ram_addr, ram_wrdata);
            end
            if (expq.size() > 0) begin
                wr_t e;
                e = expq.pop_front();
                check("write_cycle", cyc, e.cyc);
                check("write_addr", {24'd0, ram_addr}, {24'd0, e.addr});
                check("write_data", {24'd0, ram_wrdata}, {24'd0, e.data});
                check("write_done", {31'd0, capture_done}, {31'd0, e.done});
            end
        end else if (capture_done !== 1'b0) begin
            check("done_without_write", {31'd0, ram_wr}, 32'd1);
        end
    end

    task automatic apply_ctrl(input logic [15:0] w, input logic [15:0] h);
        in_control_valid = 1'b1;
        in_control_data  = {w, h, 4'h5};
        @(posedge clk); #1;
        in_control_valid = 1'b0;
        sh_w = (w == 16'd0) ? 256 : int'(w);
        sh_h = (h == 16'd0) ? 256 : int'(h);
    endtask

    // mode: 0 random pixels, 1 grey ramp {x,x,x}, 2 primaries at x<4 then random
    task automatic send_frame(input int line, input bit frz, input int npix, input int mode,
                              input int frz_off_at, input bit ctrl_start,
                              input logic [15:0] cw, input logic [15:0] ch, input int stop_at);
        int fw, fh, lastx, x, y, guard;
        bit captured;
        logic [23:0] px;
        wr_t e;
        guard = 0;
        while (video_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_before_frame", {31'd0, video_ready}, 32'd1);
        fw = sh_w;
        fh = sh_h;
        if (ctrl_start) begin
            sh_w = (cw == 16'd0) ? 256 : int'(cw);
            sh_h = (ch == 16'd0) ? 256 : int'(ch);
        end
        lastx    = ((fw < 256) ? fw : 256) - 1;
        line_sel = 16'(line);
        freeze   = frz;
        captured = 1'b0;
        for (int i = 0; i < npix; i++) begin
            if (i == stop_at) return;
            if ($urandom_range(0, 7) == 0) begin
                video_valid      = 1'b0;
                frame_sync       = 1'b0;
                in_control_valid = 1'b0;
                @(posedge clk); #1;
            end
            x = i % fw;
            y = (i / fw) % fh;
            if (mode == 1)                px = {x[7:0], x[7:0], x[7:0]};
            else if (mode == 2 && x < 4)  px = colors[x];
            else                          px = 24'($urandom);
            video_valid      = 1'b1;
            video_data       = px;
            frame_sync       = (i == npix - 1);
            in_control_valid = ctrl_start && (i == 0);
            in_control_data  = {cw, ch, 4'hA};
            if (i == frz_off_at) freeze = 1'b0;
            if (!frz && !captured && y == line && x < 256) begin
                e.cyc  = cyc + 2;
                e.addr = x[7:0];
                e.data = luma_of(px);
                e.done = (x == lastx);
                expq.push_back(e);
                if (x == lastx) captured = 1'b1;
            end
            @(posedge clk); #1;
        end
        video_valid      = 1'b0;
        frame_sync       = 1'b0;
        in_control_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("frame_writes_all_seen", expq.size(), 32'd0);
    endtask

    initial begin
        int k;
        rst              = 1'b1;
        video_valid      = 1'b0;
        video_data       = 24'd0;
        frame_sync       = 1'b0;
        in_control_data  = 36'd0;
        in_control_valid = 1'b0;
        line_sel         = 16'd0;
        freeze           = 1'b0;
        @(posedge clk); #1;
        check("reset_video_ready", {31'd0, video_ready}, 32'd0);
        check("reset_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("reset_ram_addr", {24'd0, ram_addr}, 32'd0);
        check("reset_ram_wrdata", {24'd0, ram_wrdata}, 32'd0);
        check("reset_capture_done", {31'd0, capture_done}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("ready_low_first_cycle", {31'd0, video_ready}, 32'd0);
        @(posedge clk); #1;
        check("ready_high_after", {31'd0, video_ready}, 32'd1);

        // Default geometry, grey ramp, line 5
        send_frame(5, 0, 6 * 256, 1, -1, 0, 16'd0, 16'd0, -1);
        // Primary colours at the start of line 0
        send_frame(0, 0, 256, 2, -1, 0, 16'd0, 16'd0, -1);
        // Wide frame: only x < 256 written
        apply_ctrl(16'd320, 16'd4);
        send_frame(3, 0, 4 * 320, 0, -1, 0, 16'd0, 16'd0, -1);
        // Narrow frame, height 0 means default height
        apply_ctrl(16'd100, 16'd0);
        send_frame(2, 0, 300, 0, -1, 0, 16'd0, 16'd0, -1);
        // Freeze sampled at frame start, released mid-frame, then a normal frame
        send_frame(1, 1, 300, 0, 50, 0, 16'd0, 16'd0, -1);
        send_frame(1, 0, 200, 0, -1, 0, 16'd0, 16'd0, -1);
        // frame_sync at x=50 of the selected line truncates the capture
        apply_ctrl(16'd0, 16'd0);
        send_frame(1, 0, 256 + 51, 0, -1, 0, 16'd0, 16'd0, -1);
        send_frame(0, 0, 256, 0, -1, 0, 16'd0, 16'd0, -1);
        // Selected line beyond the frame height
        send_frame(300, 0, 512, 0, -1, 0, 16'd0, 16'd0, -1);
        // Control word coincident with frame start applies one frame later
        send_frame(0, 0, 256, 0, -1, 1, 16'd64, 16'd0, -1);
        send_frame(1, 0, 128, 0, -1, 0, 16'd0, 16'd0, -1);

        // Reset in the middle of a capture
        send_frame(0, 0, 256, 0, -1, 0, 16'd0, 16'd0, 100);
        k = cyc;
        video_valid = 1'b0;
        frame_sync  = 1'b0;
        rst         = 1'b1;
        while (expq.size() > 0 && expq[expq.size() - 1].cyc > k) void'(expq.pop_back());
        @(posedge clk); #1;
        check("midreset_ram_wr", {31'd0, ram_wr}, 32'd0);
        check("midreset_ready_c1", {31'd0, video_ready}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("midreset_ready_c2", {31'd0, video_ready}, 32'd0);
        check("midreset_flushed", expq.size(), 32'd0);
        @(posedge clk); #1;
        check("midreset_ready_c3", {31'd0, video_ready}, 32'd1);
        sh_w = 256;
        sh_h = 256;
        send_frame(0, 0, 256, 0, -1, 0, 16'd0, 16'd0, -1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
